layered_video_mux: RTL and testbench

Parametrised, pipelined successor to the fixed-priority sprite/background mux in the VGA path. It selects one RGB pixel per clock from NUM_LAYERS sprite layers (index 0 = highest priority), falling back to a background pixel when no layer is visible. It adds per-layer enable masking, colour-key transparency, frame-synchronous flashing of selected layers, and per-frame collision flags for game logic. It sits between the object drawers and the VGA output register.

---
 rtl/layered_video_mux_if.sv | 30 +++
 rtl/layered_video_mux.sv | 110 +++++++++++
 tb/tb_layered_video_mux.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/layered_video_mux_if.sv
// Pixel-path bundle between the object drawers (master) and the layered mux (slave).
// Signal names match the surrounding VGA path.
interface layered_video_mux_if #(
  parameter int unsigned NUM_LAYERS = 8,
  parameter int unsigned RGB_W      = 8
);
  localparam int unsigned IdxW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

  logic [NUM_LAYERS-1:0]       layerDrawReq;
  logic [NUM_LAYERS*RGB_W-1:0] layerRGB;
  logic [NUM_LAYERS-1:0]       layerEnable;
  logic [NUM_LAYERS-1:0]       flashMask;
  logic [RGB_W-1:0]            bgRGB;
  logic                        startOfFrame;
  logic [RGB_W-1:0]            RGBOut;
  logic                        winnerValid;
  logic [IdxW-1:0]             winnerIdx;
  logic [NUM_LAYERS-1:0]       collisionFrame;
  logic                        flashPhase;

  modport master (
    output layerDrawReq, layerRGB, layerEnable, flashMask, bgRGB, startOfFrame,
    input  RGBOut, winnerValid, winnerIdx, collisionFrame, flashPhase
  );

  modport slave (
    input  layerDrawReq, layerRGB, layerEnable, flashMask, bgRGB, startOfFrame,
    output RGBOut, winnerValid, winnerIdx, collisionFrame, flashPhase
  );
endinterface

// File: rtl/layered_video_mux.sv
// Two-stage priority mux of sprite layers over a background, with colour-key transparency,
// frame-synchronous flashing and per-frame collision flags.
module layered_video_mux #(
  parameter int unsigned     NUM_LAYERS   = 8,
  parameter int unsigned     RGB_W        = 8,
  parameter logic [RGB_W-1:0] TRANSPARENT = 8'hFF,
  parameter int unsigned     FLASH_FRAMES = 16
) (
  input logic                 clk,
  input logic                 resetN,
  layered_video_mux_if.slave  bus
);
  localparam int unsigned IdxW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int unsigned CntW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

  logic [NUM_LAYERS-1:0]       vis_d, vis_q;
  logic [NUM_LAYERS*RGB_W-1:0] rgb_q;
  logic [RGB_W-1:0]            bg_q;
  logic                        sof1_q;
  logic [RGB_W-1:0]            rgb_out_d, rgb_out_q;
  logic                        winner_valid_d, winner_valid_q;
  logic [IdxW-1:0]             winner_idx_d, winner_idx_q;
  logic [NUM_LAYERS-1:0]       hit;
  logic [NUM_LAYERS-1:0]       col_acc_d, col_acc_q;
  logic [NUM_LAYERS-1:0]       collision_frame_d, collision_frame_q;
  logic [CntW-1:0]             frame_cnt_d, frame_cnt_q;
  logic                        flash_phase_d, flash_phase_q;

  always_comb begin
    vis_d = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      vis_d[i] = bus.layerDrawReq[i] & bus.layerEnable[i]
               & (bus.layerRGB[i*RGB_W +: RGB_W] != TRANSPARENT)
               & ~(bus.flashMask[i] & flash_phase_q);
    end
  end

  always_comb begin
    frame_cnt_d   = frame_cnt_q;
    flash_phase_d = flash_phase_q;
    if (bus.startOfFrame) begin
      if (frame_cnt_q == CntW'(FLASH_FRAMES - 1)) begin
        frame_cnt_d   = '0;
        flash_phase_d = ~flash_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + CntW'(1);
      end
    end
  end

  // Scan from the top down so the lowest visible index is the last writer.
  always_comb begin
    rgb_out_d      = bg_q;
    winner_valid_d = 1'b0;
    winner_idx_d   = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (vis_q[i]) begin
        rgb_out_d      = rgb_q[i*RGB_W +: RGB_W];
        winner_valid_d = 1'b1;
        winner_idx_d   = IdxW'(i);
      end
    end
  end

  // v & (v-1) is non-zero exactly when two or more layers are visible.
  always_comb begin
    hit = ((vis_q & (vis_q - NUM_LAYERS'(1))) != '0) ? vis_q : '0;
    if (sof1_q) begin
      collision_frame_d = col_acc_q;
      col_acc_d         = hit;
    end else begin
      collision_frame_d = collision_frame_q;
      col_acc_d         = col_acc_q | hit;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      vis_q             <= '0;
      rgb_q             <= '0;
      bg_q              <= '0;
      sof1_q            <= 1'b0;
      rgb_out_q         <= '0;
      winner_valid_q    <= 1'b0;
      winner_idx_q      <= '0;
      col_acc_q         <= '0;
      collision_frame_q <= '0;
      frame_cnt_q       <= '0;
      flash_phase_q     <= 1'b0;
    end else begin
      vis_q             <= vis_d;
      rgb_q             <= bus.layerRGB;
      bg_q              <= bus.bgRGB;
      sof1_q            <= bus.startOfFrame;
      rgb_out_q         <= rgb_out_d;
      winner_valid_q    <= winner_valid_d;
      winner_idx_q      <= winner_idx_d;
      col_acc_q         <= col_acc_d;
      collision_frame_q <= collision_frame_d;
      frame_cnt_q       <= frame_cnt_d;
      flash_phase_q     <= flash_phase_d;
    end
  end

  assign bus.RGBOut         = rgb_out_q;
  assign bus.winnerValid    = winner_valid_q;
  assign bus.winnerIdx      = winner_idx_q;
  assign bus.collisionFrame = collision_frame_q;
  assign bus.flashPhase     = flash_phase_q;
endmodule

// File: tb/tb_layered_video_mux.sv
// Randomized bench for layered_video_mux: a history-based model predicts every output
// from the recorded input stream, plus directed scenarios with literal expectations.
module tb_layered_video_mux;
  localparam int NL   = 8;
  localparam int W    = 8;
  localparam int FF   = 2;
  localparam int MAXC = 4096;
  localparam logic [W-1:0] KEY = 8'hFF;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  layered_video_mux_if #(.NUM_LAYERS(NL), .RGB_W(W)) bus ();

  layered_video_mux #(
    .NUM_LAYERS  (NL),
    .RGB_W       (W),
    .TRANSPARENT (KEY),
    .FLASH_FRAMES(FF)
  ) dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  // Input history, indexed by rising-edge number.
  logic [NL-1:0]   a_req [MAXC];
  logic [NL*W-1:0] a_rgb [MAXC];
  logic [NL-1:0]   a_en  [MAXC];
  logic [NL-1:0]   a_fm  [MAXC];
  logic [W-1:0]    a_bg  [MAXC];
  logic            a_sof [MAXC];
  int              a_sofcnt [MAXC];  // frame pulses seen since reset, before this edge
  int cyc = 0;
  int epoch = 1 << 30;
  int sof_run = 0;
  logic prev_high = 1'b0;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", nm, cyc, got, exp);
    end
  endtask

  always @(posedge clk) begin
    if (resetN) begin
      if (!prev_high) begin
        epoch   = cyc;
        sof_run = 0;
      end
      a_req[cyc]    = bus.layerDrawReq;
      a_rgb[cyc]    = bus.layerRGB;
      a_en[cyc]     = bus.layerEnable;
      a_fm[cyc]     = bus.flashMask;
      a_bg[cyc]     = bus.bgRGB;
      a_sof[cyc]    = bus.startOfFrame;
      a_sofcnt[cyc] = sof_run;
      if (bus.startOfFrame) sof_run++;
    end else begin
      epoch = 1 << 30;
    end
    prev_high = resetN;
    cyc++;
  end

  function automatic logic [NL-1:0] vis_of(input int j);
    logic [NL-1:0] v;
    logic ph;
    ph = ((a_sofcnt[j] / FF) % 2) == 1;
    for (int i = 0; i < NL; i++)
      v[i] = a_req[j][i] && a_en[j][i] && (a_rgb[j][i*W +: W] != KEY) && !(a_fm[j][i] && ph);
    return v;
  endfunction

  function automatic logic [NL-1:0] hit_of(input int j);
    logic [NL-1:0] v;
    v = vis_of(j);
    return ($countones(v) >= 2) ? v : '0;
  endfunction

  function automatic logic [NL-1:0] col_after(input int k);
    int s;
    int p;
    logic [NL-1:0] acc;
    s = -1;
    for (int j = k - 1; j >= epoch; j--) if (a_sof[j]) begin s = j; break; end
    if (s < 0) return '0;
    p = epoch;
    for (int j = s - 1; j >= epoch; j--) if (a_sof[j]) begin p = j; break; end
    acc = '0;
    for (int j = p; j < s; j++) acc |= hit_of(j);
    return acc;
  endfunction

  always @(negedge clk) begin
    if (cyc > 0) begin
      int k;
      logic [W-1:0]  e_rgb;
      logic          e_val;
      logic [2:0]    e_idx;
      logic [NL-1:0] v;
      k = cyc - 1;
      if (!resetN || k < epoch) begin
        cmp("rst_rgb", 32'(bus.RGBOut), 0);
        cmp("rst_valid", 32'(bus.winnerValid), 0);
        cmp("rst_idx", 32'(bus.winnerIdx), 0);
        cmp("rst_col", 32'(bus.collisionFrame), 0);
        cmp("rst_phase", 32'(bus.flashPhase), 0);
      end else begin
        e_rgb = '0; e_val = 1'b0; e_idx = '0;
        if (k - 1 >= epoch) begin
          v = vis_of(k - 1);
          e_rgb = a_bg[k-1];
          for (int i = 0; i < NL; i++) if (v[i]) begin
            e_rgb = a_rgb[k-1][i*W +: W]; e_val = 1'b1; e_idx = 3'(i); break;
          end
        end
        cmp("model_rgb", 32'(bus.RGBOut), 32'(e_rgb));
        cmp("model_valid", 32'(bus.winnerValid), 32'(e_val));
        cmp("model_idx", 32'(bus.winnerIdx), 32'(e_idx));
        cmp("model_col", 32'(bus.collisionFrame), 32'(col_after(k)));
        cmp("model_phase", 32'(bus.flashPhase),
            32'(((a_sofcnt[k] + (a_sof[k] ? 1 : 0)) / FF) % 2));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input logic [NL-1:0] req, input logic [NL*W-1:0] rgb,
                    input logic [W-1:0] bg, input logic sof);
    bus.layerDrawReq = req;
    bus.layerRGB     = rgb;
    bus.bgRGB        = bg;
    bus.startOfFrame = sof;
    tick();
  endtask

  logic [NL*W-1:0] r;

  initial begin
    bus.layerDrawReq = '0; bus.layerRGB = '0; bus.layerEnable = '1;
    bus.flashMask = '0; bus.bgRGB = '0; bus.startOfFrame = 1'b0;
    repeat (3) tick();
    cmp("lit_reset_rgb", 32'(bus.RGBOut), 0);
    resetN = 1'b1;

    // Priority: layers 2 and 5 request, 2 wins.
    r = '0; r[2*W +: W] = 8'h1C; r[5*W +: W] = 8'hE0;
    px(8'b0010_0100, r, 8'h00, 1'b0); tick();
    cmp("lit_prio_rgb", 32'(bus.RGBOut), 32'h1C);
    cmp("lit_prio_idx", 32'(bus.winnerIdx), 2);
    cmp("lit_prio_valid", 32'(bus.winnerValid), 1);
    px(8'h00, r, 8'h03, 1'b0); tick();
    cmp("lit_bg_rgb", 32'(bus.RGBOut), 32'h03);
    cmp("lit_bg_valid", 32'(bus.winnerValid), 0);

    // Colour key on layer 0 lets layer 3 through; then disable layer 3.
    r = '0; r[0 +: W] = 8'hFF; r[3*W +: W] = 8'h44;
    px(8'b0000_1001, r, 8'h03, 1'b0); tick();
    cmp("lit_key_rgb", 32'(bus.RGBOut), 32'h44);
    cmp("lit_key_idx", 32'(bus.winnerIdx), 3);
    bus.layerEnable = 8'hF7;
    tick(); tick();
    cmp("lit_en_rgb", 32'(bus.RGBOut), 32'h03);
    cmp("lit_en_valid", 32'(bus.winnerValid), 0);
    bus.layerEnable = '1;

    // Collision frame: 1&4 overlap once, 6 alone elsewhere.
    r = '0; r[1*W +: W] = 8'h11; r[4*W +: W] = 8'h22; r[6*W +: W] = 8'h66;
    px(8'h00, r, 8'h00, 1'b1);
    px(8'b0001_0010, r, 8'h00, 1'b0);
    px(8'b0100_0000, r, 8'h00, 1'b0);
    px(8'h00, r, 8'h00, 1'b0);
    px(8'h00, r, 8'h00, 1'b1);
    px(8'h00, r, 8'h00, 1'b0);
    cmp("lit_col_set", 32'(bus.collisionFrame), 32'h12);
    px(8'b0100_0000, r, 8'h00, 1'b0);
    px(8'b0000_0010, r, 8'h00, 1'b0);
    px(8'h00, r, 8'h00, 1'b1);
    px(8'h00, r, 8'h00, 1'b0);
    cmp("lit_col_clear", 32'(bus.collisionFrame), 0);

    // Reset mid-frame discards accumulated collision.
    px(8'h00, r, 8'h00, 1'b1);
    px(8'b0001_0010, r, 8'h00, 1'b0);
    px(8'h00, r, 8'h00, 1'b0);
    resetN = 1'b0;
    #1;
    cmp("lit_midrst_rgb", 32'(bus.RGBOut), 0);
    repeat (3) tick();
    resetN = 1'b1;
    px(8'h00, r, 8'h00, 1'b0);
    px(8'h00, r, 8'h00, 1'b1);
    px(8'h00, r, 8'h00, 1'b0);
    cmp("lit_midrst_col", 32'(bus.collisionFrame), 0);

    // Flash: layer 0 masked, FLASH_FRAMES=2.
    resetN = 1'b0;
    repeat (2) tick();
    resetN = 1'b1;
    bus.flashMask = 8'h01;
    r = '0; r[0 +: W] = 8'h55;
    for (int f = 0; f < 4; f++) begin
      for (int p = 0; p < 6; p++) begin
        px(8'h01, r, 8'h00, p == 0);
        if (p == 4) begin
          cmp("lit_flash_rgb", 32'(bus.RGBOut), (f == 1 || f == 2) ? 32'h00 : 32'h55);
          cmp("lit_flash_phase", 32'(bus.flashPhase), (f == 1 || f == 2) ? 1 : 0);
        end
      end
    end

    // Randomized traffic with back-to-back frame pulses and a mid-run reset.
    for (int n = 0; n < 1500; n++) begin
      logic [NL*W-1:0] rr;
      for (int i = 0; i < NL; i++)
        rr[i*W +: W] = ($urandom % 6 == 0) ? 8'hFF : 8'($urandom);
      bus.layerEnable = ($urandom % 8 == 0) ? 8'($urandom) : 8'hFF;
      bus.flashMask   = 8'($urandom);
      if (n == 700) resetN = 1'b0;
      if (n == 703) resetN = 1'b1;
      px(8'($urandom & $urandom & $urandom), rr,
         ($urandom % 8 == 0) ? 8'hFF : 8'($urandom),
         ($urandom % 12 == 0) || (n % 97 == 1) || (n % 97 == 2));
    end
    bus.startOfFrame = 1'b0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
